// File: rtl/trigger_sequencer.sv
// Trigger sequencer: pops TTC trigger words, collects one acquisition word per enabled channel, hands off to readout.
// Optional build macro TRIG_MISMATCH_CHECK_EN enables trig-num/type comparison of popped acquisition words.
module trigger_sequencer #(
  parameter int NUM_CHAN = 5,
  parameter int TS_W     = 44
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trig_fifo_valid,
  input  logic [127:0]           trig_fifo_data,
  output logic                   trig_fifo_ready,
  input  logic [NUM_CHAN-1:0]    acq_fifo_valid,
  input  logic [32*NUM_CHAN-1:0] acq_fifo_data,
  output logic [NUM_CHAN-1:0]    acq_fifo_ready,
  input  logic [NUM_CHAN-1:0]    chan_en,
  input  logic                   readout_ready,
  input  logic                   readout_done,
  output logic                   send_empty_event,
  output logic                   initiate_readout,
  output logic [23:0]            ttc_event_num,
  output logic [23:0]            ttc_trig_num,
  output logic [2:0]             ttc_trig_type,
  output logic [TS_W-1:0]        ttc_trig_timestamp,
  output logic [6:0]             state,
  output logic                   error_trig_num,
  output logic                   error_trig_type,
  output logic [NUM_CHAN-1:0]    error_chan,
  output logic [31:0]            trig_count
);

  typedef enum logic [6:0] {
    S_IDLE       = 7'b0000001,
    S_READ_TRIG  = 7'b0000010,
    S_SEND_EMPTY = 7'b0000100,
    S_COLLECT    = 7'b0001000,
    S_READOUT    = 7'b0010000,
    S_ERR_NUM    = 7'b0100000,
    S_ERR_TYPE   = 7'b1000000
  } state_t;

  state_t              state_q, state_d;
  logic                empty_q, empty_d;
  logic [2:0]          type_q, type_d;
  logic [23:0]         event_q, event_d;
  logic [23:0]         num_q, num_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [NUM_CHAN-1:0] active_q, active_d;
  logic [NUM_CHAN-1:0] collected_q, collected_d;
  logic [31:0]         trig_count_q, trig_count_d;
  logic                send_empty_q, send_empty_d;
  logic                init_q, init_d;
  logic [NUM_CHAN-1:0] pop;
`ifdef TRIG_MISMATCH_CHECK_EN
  logic [NUM_CHAN-1:0] error_chan_q, error_chan_d;
  logic [NUM_CHAN-1:0] num_mis, type_mis;
`endif

  // Only a subset of the trigger/acq word bits carry fields.
  logic unused_data;
  assign unused_data = ^{trig_fifo_data, acq_fifo_data};

  always_comb begin
    state_d      = state_q;
    empty_d      = empty_q;
    type_d       = type_q;
    event_d      = event_q;
    num_d        = num_q;
    ts_d         = ts_q;
    active_d     = active_q;
    collected_d  = collected_q;
    trig_count_d = trig_count_q;
    send_empty_d = 1'b0;
    init_d       = 1'b0;
    trig_fifo_ready = 1'b0;
    pop          = '0;
`ifdef TRIG_MISMATCH_CHECK_EN
    error_chan_d = error_chan_q;
    num_mis      = '0;
    type_mis     = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (trig_fifo_valid) begin
          trig_fifo_ready = 1'b1;
          empty_d      = trig_fifo_data[95];
          type_d       = trig_fifo_data[94:92];
          event_d      = trig_fifo_data[91:68];
          num_d        = trig_fifo_data[67:44];
          ts_d         = trig_fifo_data[TS_W-1:0];
          active_d     = chan_en;
          collected_d  = '0;
          trig_count_d = trig_count_q + 32'd1;
          state_d      = S_READ_TRIG;
        end
      end
      S_READ_TRIG: begin
        if (empty_q || (active_q == '0)) begin
          if (readout_ready) begin
            send_empty_d = 1'b1;
            init_d       = 1'b1;
            state_d      = S_SEND_EMPTY;
          end
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        pop         = active_q & ~collected_q & acq_fifo_valid;
        collected_d = collected_q | pop;
`ifdef TRIG_MISMATCH_CHECK_EN
        for (int unsigned k = 0; k < NUM_CHAN; k++) begin
          if (pop[k]) begin
            num_mis[k]  = (acq_fifo_data[32*k +: 24] != num_q);
            type_mis[k] = (acq_fifo_data[32*k+24 +: 3] != type_q);
          end
        end
        if ((num_mis | type_mis) != '0) begin
          error_chan_d = error_chan_q | num_mis | type_mis;
          state_d      = (num_mis != '0) ? S_ERR_NUM : S_ERR_TYPE;
        end else
`endif
        if ((collected_q == active_q) && readout_ready) begin
          init_d  = 1'b1;
          state_d = S_READOUT;
        end
      end
      S_SEND_EMPTY, S_READOUT: begin
        if (readout_done) state_d = S_IDLE;
      end
      S_ERR_NUM, S_ERR_TYPE: state_d = state_q;
      default: state_d = S_IDLE;
    endcase
    // No FIFO may be popped while reset is asserted.
    if (reset) begin
      trig_fifo_ready = 1'b0;
      pop             = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      empty_q      <= 1'b0;
      type_q       <= '0;
      event_q      <= '0;
      num_q        <= '0;
      ts_q         <= '0;
      active_q     <= '0;
      collected_q  <= '0;
      trig_count_q <= '0;
      send_empty_q <= 1'b0;
      init_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      empty_q      <= empty_d;
      type_q       <= type_d;
      event_q      <= event_d;
      num_q        <= num_d;
      ts_q         <= ts_d;
      active_q     <= active_d;
      collected_q  <= collected_d;
      trig_count_q <= trig_count_d;
      send_empty_q <= send_empty_d;
      init_q       <= init_d;
    end
  end

`ifdef TRIG_MISMATCH_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) error_chan_q <= '0;
    else       error_chan_q <= error_chan_d;
  end
  assign error_chan = error_chan_q;
`else
  assign error_chan = '0;
`endif

  assign acq_fifo_ready     = pop;
  assign send_empty_event   = send_empty_q;
  assign initiate_readout   = init_q;
  assign ttc_event_num      = event_q;
  assign ttc_trig_num       = num_q;
  assign ttc_trig_type      = type_q;
  assign ttc_trig_timestamp = ts_q;
  assign state              = state_q;
  assign error_trig_num     = state_q[5];
  assign error_trig_type    = state_q[6];
  assign trig_count         = trig_count_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: directed table, hand-written corner sequences and
// randomized transactions checked against a per-trigger behavioural model.
module tb_trigger_sequencer;
  localparam int NC  = 5;
  localparam int TSW = 44;
  localparam logic [6:0] ST_IDLE = 7'b0000001, ST_SEND_EMPTY = 7'b0000100,
                         ST_READOUT = 7'b0010000, ST_ERR_NUM = 7'b0100000, ST_ERR_TYPE = 7'b1000000;

  logic clk = 1'b0, reset = 1'b1;
  logic trig_fifo_valid = 1'b0, trig_fifo_ready;
  logic [127:0] trig_fifo_data = '0;
  logic [NC-1:0] acq_fifo_valid = '0, acq_fifo_ready, chan_en = '0, error_chan;
  logic [32*NC-1:0] acq_fifo_data = '0;
  logic readout_ready = 1'b0, readout_done = 1'b0, send_empty_event, initiate_readout;
  logic [23:0] ttc_event_num, ttc_trig_num;
  logic [2:0] ttc_trig_type;
  logic [TSW-1:0] ttc_trig_timestamp;
  logic [6:0] state;
  logic error_trig_num, error_trig_type;
  logic [31:0] trig_count;

  trigger_sequencer #(.NUM_CHAN(NC), .TS_W(TSW)) dut (
    .clk(clk), .reset(reset), .trig_fifo_valid(trig_fifo_valid), .trig_fifo_data(trig_fifo_data),
    .trig_fifo_ready(trig_fifo_ready), .acq_fifo_valid(acq_fifo_valid), .acq_fifo_data(acq_fifo_data),
    .acq_fifo_ready(acq_fifo_ready), .chan_en(chan_en), .readout_ready(readout_ready),
    .readout_done(readout_done), .send_empty_event(send_empty_event), .initiate_readout(initiate_readout),
    .ttc_event_num(ttc_event_num), .ttc_trig_num(ttc_trig_num), .ttc_trig_type(ttc_trig_type),
    .ttc_trig_timestamp(ttc_trig_timestamp), .state(state), .error_trig_num(error_trig_num),
    .error_trig_type(error_trig_type), .error_chan(error_chan), .trig_count(trig_count));

  always #4 clk = ~clk;

  int vec_cnt = 0, err_cnt = 0;
  // Model of the latched trigger and per-channel arrival delays for the next transaction.
  logic [31:0] m_count = '0;
  logic [23:0] m_ev = '0, m_num = '0;
  logic [2:0]  m_typ = '0;
  logic [TSW-1:0] m_ts = '0;
  int dly [NC];
  logic [23:0] next_num;
  bit use_next_num = 0;

  typedef struct {
    logic [NC-1:0] en; logic empty; logic [NC-1:0] late; int late_dly;
    logic [23:0] num; logic [NC-1:0] exp_first; logic exp_empty;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; trig_fifo_valid = 1'b1; acq_fifo_valid = '1; readout_done = 1'b0;
    #1;
    chk("rst_trig_ready", trig_fifo_ready, 0);
    chk("rst_acq_ready", acq_fifo_ready, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; trig_fifo_valid = 1'b0; acq_fifo_valid = '0;
    #1;
    chk("rst_state", state, ST_IDLE);
    chk("rst_count", trig_count, 0);
    chk("rst_fields", {ttc_event_num, ttc_trig_num, ttc_trig_type, ttc_trig_timestamp != '0}, 0);
    chk("rst_pulses", {initiate_readout, send_empty_event}, 0);
    chk("rst_error_chan", error_chan, 0);
    m_count = '0; m_ev = '0; m_num = '0; m_typ = '0; m_ts = '0;
  endtask

  task automatic put_trig(input logic empty, input logic [2:0] typ, input logic [23:0] ev,
                          input logic [23:0] num, input logic [TSW-1:0] ts);
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    d[95] = empty; d[94:92] = typ; d[91:68] = ev; d[67:44] = num; d[TSW-1:0] = ts;
    trig_fifo_data = d;
    trig_fifo_valid = 1'b1;
  endtask

  task automatic run_trig(input logic [NC-1:0] en, input logic empty, input int rr_dly, input bit noise,
                          output logic [NC-1:0] first_ready, output logic saw_empty);
    logic [NC-1:0] pm, expr;
    int go;
    bit done, empty_path, pulse_now;
    first_ready = 'x; saw_empty = 1'b0;
    @(negedge clk);
    m_ev = 24'($urandom); m_num = use_next_num ? next_num : 24'($urandom);
    m_typ = 3'($urandom); m_ts = {12'($urandom), 32'($urandom)};
    put_trig(empty, m_typ, m_ev, m_num, m_ts);
    chan_en = en; readout_ready = 1'b0;
    acq_fifo_valid = noise ? NC'($urandom) : '0;
    readout_done = noise ? 1'($urandom) : 1'b0;
    m_count = m_count + 32'd1;
    #1;
    chk("accept_trig_ready", trig_fifo_ready, 1);
    chk("accept_no_acq_pop", acq_fifo_ready, 0);
    @(posedge clk);
    pm = '0; go = -1; done = 0;
    empty_path = empty || (en == '0);
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      trig_fifo_valid = noise ? 1'($urandom) : 1'b0;
      trig_fifo_data = {$urandom, $urandom, $urandom, $urandom};
      chan_en = noise ? NC'($urandom) : en;
      readout_ready = (c >= rr_dly);
      pulse_now = (go >= 0) && (c == go + 1);
      readout_done = (noise && !pulse_now) ? 1'($urandom) : 1'b0;
      for (int k = 0; k < NC; k++) begin
        acq_fifo_valid[k] = en[k] ? ((c >= dly[k]) && !pm[k]) : (noise ? 1'($urandom) : 1'b1);
        acq_fifo_data[32*k +: 32] = en[k] ? {5'b0, m_typ, m_num} : $urandom;
      end
      expr = (!empty_path && c >= 1 && go < 0) ? (en & ~pm & acq_fifo_valid) : '0;
      #1;
      chk("acq_ready", acq_fifo_ready, expr);
      chk("trig_ready_busy", trig_fifo_ready, 0);
      chk("initiate_readout", initiate_readout, pulse_now);
      chk("send_empty_event", send_empty_event, pulse_now && empty_path);
      if (c == 1) first_ready = acq_fifo_ready;
      if (pulse_now) begin
        chk("handoff_state", state, empty_path ? ST_SEND_EMPTY : ST_READOUT);
        saw_empty = send_empty_event;
        done = 1;
      end
      if (go < 0 && readout_ready && (empty_path || (c >= 1 && pm == en))) go = c;
      pm = pm | expr;
      @(posedge clk);
    end
    if (!done) chk("handoff_timeout", 0, 1);
    repeat (noise ? $urandom_range(0, 3) : 0) begin
      @(negedge clk);
      readout_done = 1'b0; acq_fifo_valid = '1; trig_fifo_valid = 1'b0;
      #1;
      chk("wait_done_state", state, empty_path ? ST_SEND_EMPTY : ST_READOUT);
      chk("wait_done_quiet", {acq_fifo_ready, initiate_readout, send_empty_event}, 0);
      @(posedge clk);
    end
    @(negedge clk);
    readout_done = 1'b1; trig_fifo_valid = 1'b0; acq_fifo_valid = '0;
    #1;
    chk("ttc_event_num", ttc_event_num, m_ev);
    chk("ttc_trig_num", ttc_trig_num, m_num);
    chk("ttc_trig_type", ttc_trig_type, m_typ);
    chk("ttc_trig_timestamp", ttc_trig_timestamp, m_ts);
    chk("trig_count", trig_count, m_count);
    @(posedge clk);
    @(negedge clk);
    readout_done = 1'b0;
    #1;
    chk("back_to_idle", state, ST_IDLE);
  endtask

  task automatic err_case(input logic [NC-1:0] bad_num, input logic [NC-1:0] bad_type,
                          input logic [6:0] exp_state, input logic [NC-1:0] exp_chan);
    @(negedge clk);
    put_trig(1'b0, 3'd2, 24'h000777, 24'h000123, '0);
    chan_en = '1; readout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trig_fifo_valid = 1'b0;
    for (int k = 0; k < NC; k++)
      acq_fifo_data[32*k +: 32] = {5'b0, bad_type[k] ? 3'd5 : 3'd2, bad_num[k] ? 24'h000124 : 24'h000123};
    acq_fifo_valid = '1;
    @(posedge clk);
    @(negedge clk);
    #1 chk("err_pop_all", acq_fifo_ready, '1);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      readout_done = 1'b1; trig_fifo_valid = 1'b1; acq_fifo_valid = '1;
      #1;
      chk("err_state", state, exp_state);
      chk("err_flags", {error_trig_type, error_trig_num}, {exp_state[6], exp_state[5]});
      chk("err_chan", error_chan, exp_chan);
      chk("err_no_pops", {trig_fifo_ready, acq_fifo_ready}, 0);
      @(posedge clk);
    end
    readout_done = 1'b0;
    do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC-1:0] fr, en;
    logic se;
    tbl[0] = '{5'b10101, 1'b0, 5'b00000, 0,  24'h000123, 5'b10101, 1'b0};
    tbl[1] = '{5'b11111, 1'b0, 5'b00100, 10, 24'h000456, 5'b11011, 1'b0};
    tbl[2] = '{5'b11111, 1'b1, 5'b00000, 0,  24'h000001, 5'b00000, 1'b1};
    tbl[3] = '{5'b00000, 1'b0, 5'b00000, 0,  24'h000002, 5'b00000, 1'b1};
    tbl[4] = '{5'b00001, 1'b0, 5'b00000, 0,  24'hFFFFFF, 5'b00001, 1'b0};
    tbl[5] = '{5'b11110, 1'b0, 5'b11110, 3,  24'h000000, 5'b00000, 1'b0};

    repeat (2) @(posedge clk);
    do_reset();

    use_next_num = 1;
    foreach (tbl[i]) begin
      for (int k = 0; k < NC; k++) dly[k] = tbl[i].late[k] ? tbl[i].late_dly : 0;
      next_num = tbl[i].num;
      run_trig(tbl[i].en, tbl[i].empty, 0, 0, fr, se);
      chk("tbl_first_ready", fr, tbl[i].exp_first);
      chk("tbl_empty_path", se, tbl[i].exp_empty);
    end
    use_next_num = 0;

    for (int t = 0; t < 150; t++) begin
      for (int k = 0; k < NC; k++) dly[k] = $urandom_range(0, 6);
      en = NC'($urandom);
      run_trig(en, ($urandom_range(0, 3) == 0), $urandom_range(0, 8), 1, fr, se);
    end

    // Reset in COLLECT after two of three channels popped; the partial mask must be dropped.
    do_reset();
    @(negedge clk);
    put_trig(1'b0, 3'd1, 24'h1, 24'h42, '0);
    chan_en = 5'b00111; readout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trig_fifo_valid = 1'b0; acq_fifo_valid = 5'b00011;
    @(posedge clk);
    @(negedge clk);
    #1 chk("mid_pop_two", acq_fifo_ready, 5'b00011);
    @(posedge clk);
    @(negedge clk);
    acq_fifo_valid = 5'b00111; reset = 1'b1;
    #1 chk("mid_reset_no_pop", acq_fifo_ready, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; acq_fifo_valid = '0;
    #1;
    chk("mid_reset_state", state, ST_IDLE);
    chk("mid_reset_count", trig_count, 0);
    chk("mid_reset_pulse", initiate_readout, 0);
    m_count = '0;
    dly[0] = 0; dly[1] = 0; dly[2] = 4; dly[3] = 0; dly[4] = 0;
    run_trig(5'b00111, 1'b0, 0, 0, fr, se);
    chk("post_reset_first", fr, 5'b00011);

    // Counter wrap: preload the count to its maximum, then accept one trigger.
    @(negedge clk);
    force dut.trig_count_q = 32'hFFFF_FFFF;
    #1 release dut.trig_count_q;
    m_count = 32'hFFFF_FFFF;
    for (int k = 0; k < NC; k++) dly[k] = 0;
    run_trig(5'b00001, 1'b0, 0, 0, fr, se);
    chk("count_wrap", trig_count, 0);

`ifdef TRIG_MISMATCH_CHECK_EN
    do_reset();
    err_case(5'b01000, 5'b00000, ST_ERR_NUM, 5'b01000);
    err_case(5'b00000, 5'b00010, ST_ERR_TYPE, 5'b00010);
    err_case(5'b00100, 5'b10000, ST_ERR_NUM, 5'b10100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/trigger_sequencer.md
TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

Interface
REQ-001 Parameter NUM_CHAN, default 5, number of acquisition event FIFOs (1..16).
REQ-002 Parameter TS_W, default 44, trigger timestamp width.
REQ-003 Ports: clk  in  1  125 MHz clock; reset  in  1  reset, synchronous, active-high.
REQ-004 Ports: trig_fifo_valid  in  1; trig_fifo_data  in  128; trig_fifo_ready  out  1  TTC trigger FIFO pop.
REQ-005 Ports: acq_fifo_valid  in  NUM_CHAN; acq_fifo_data  in  32*NUM_CHAN  (channel k at bits 32k+31:32k); acq_fifo_ready  out  NUM_CHAN.
REQ-006 Ports: chan_en  in  NUM_CHAN  channel enable mask, sampled in IDLE on trigger acceptance.
REQ-007 Ports: readout_ready  in  1; readout_done  in  1; send_empty_event  out  1; initiate_readout  out  1.
REQ-008 Ports: ttc_event_num  out  24; ttc_trig_num  out  24; ttc_trig_type  out  3; ttc_trig_timestamp  out  TS_W.
REQ-009 Ports: state  out  7  one-hot; error_trig_num  out  1; error_trig_type  out  1; error_chan  out  NUM_CHAN; trig_count  out  32  accepted triggers.

Function
REQ-010 Trigger word fields SHALL be: [95] empty flag, [94:92] type, [91:68] event num, [67:44] trig num, [TS_W-1:0] timestamp.
REQ-011 Acq word fields SHALL be: [26:24] type, [23:0] trig num.
REQ-012 States SHALL be one-hot bits IDLE=0, READ_TRIG=1, SEND_EMPTY=2, COLLECT=3, READOUT=4, ERR_NUM=5, ERR_TYPE=6.
REQ-013 IDLE: on trig_fifo_valid, trig_fifo_ready=1 same cycle (combinational), latch fields and chan_en into active mask, trig_count+1 (wraps at 2^32), go READ_TRIG.
REQ-014 READ_TRIG: if empty flag or active mask==0, wait for readout_ready then pulse send_empty_event and initiate_readout one cycle, go SEND_EMPTY; else go COLLECT next cycle.
REQ-015 COLLECT: for every active, not-yet-collected channel with valid high, acq_fifo_ready[k]=1 same cycle; multiple channels SHALL pop in one cycle; collected mask bit set on pop.
REQ-016 Each active channel SHALL be popped exactly once per trigger; inactive channels SHALL never be popped.
REQ-017 When collected mask equals active mask and readout_ready=1, pulse initiate_readout one cycle, go READOUT; else stay.
REQ-018 SEND_EMPTY/READOUT: on readout_done go IDLE; readout_done in any other state SHALL be ignored.
REQ-019 send_empty_event, initiate_readout, ready outputs SHALL default 0 in all unspecified cases.
REQ-020 ERR_NUM and ERR_TYPE SHALL be terminal until reset; error_trig_num/error_trig_type = corresponding state bit.
REQ-021 Latched ttc_* outputs SHALL hold until next trigger acceptance.

Reset
REQ-022 Reset SHALL force state=IDLE (7'b0000001), all latched fields, masks, error_chan, trig_count to 0; no FIFO pop in reset cycle.
REQ-023 Reset mid-COLLECT SHALL discard partial collected mask; already-popped words are lost.

Configuration
REQ-024 Macro TRIG_MISMATCH_CHECK_EN defined: each popped acq word compared to latched ttc_trig_num[23:0] and ttc_trig_type; num mismatch -> ERR_NUM next cycle, else type mismatch -> ERR_TYPE; error_chan bit k set for each mismatching channel popped that cycle; num takes priority over type.
REQ-025 Macro undefined: no comparison; ERR states unreachable; error_chan tied 0.

Verification
REQ-026 Trigger empty flag=1, readout_ready=1 -> send_empty_event+initiate_readout single pulse 2 cycles after pop; no acq pops; readout_done -> IDLE.
REQ-027 chan_en=5'b10101, all valid, matching trig num 0x000123 -> acq_fifo_ready=5'b10101 one cycle, initiate_readout once, channels 1,3 untouched.
REQ-028 Channel 2 valid 10 cycles late, others immediate -> initiate_readout only after channel 2 pop.
REQ-029 With macro, channel 3 trig num 0x000124 vs 0x000123 -> state=ERR_NUM, error_trig_num=1, error_chan=5'b01000, persists until reset.
REQ-030 Reset asserted mid-COLLECT with 2 of 3 channels popped -> state=IDLE, outputs 0, next trigger requires all 3 pops.
REQ-031 2^32 triggers preload/force -> trig_count wraps to 0.
